// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite config arbiter.
package axi_lite_arb_pkg;

    localparam int N_REQ = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WB,
        RA,
        RD,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant; the last_grant history register lives in the parent.
module rr_arbiter_2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_idx
);

    always_comb begin
        grant_idx = 1'b0;
        if (req_valid == 2'b10)
            grant_idx = 1'b1;
        else if (req_valid == 2'b11)
            grant_idx = ~last_grant;
        grant = (req_valid == 2'b00) ? 2'b00 : (grant_idx ? 2'b10 : 2'b01);
    end

endmodule

// File: rtl/axi_lite_cfg_arbiter.sv
// Shares one AXI4-Lite master port between two register-access requesters,
// one transaction at a time, with the result routed back to its originator.
module axi_lite_cfg_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                                     ACLK,
    input  logic                                     ARESET,
    input  logic [N_REQ-1:0]                         req_valid,
    output logic [N_REQ-1:0]                         req_ready,
    input  logic [N_REQ-1:0]                         req_we,
    input  logic [N_REQ-1:0][C_ADDR_WIDTH-1:0]       req_addr,
    input  logic [N_REQ-1:0][C_DATA_WIDTH-1:0]       req_wdata,
    input  logic [N_REQ-1:0][C_DATA_WIDTH/8-1:0]     req_wstrb,
    output logic [N_REQ-1:0]                         rsp_valid,
    output logic [C_DATA_WIDTH-1:0]                  rsp_rdata,
    output logic [1:0]                               rsp_resp,
    output logic [C_ADDR_WIDTH-1:0]                  M_AXI_AWADDR,
    output logic [2:0]                               M_AXI_AWPROT,
    output logic                                     M_AXI_AWVALID,
    input  logic                                     M_AXI_AWREADY,
    output logic [C_DATA_WIDTH-1:0]                  M_AXI_WDATA,
    output logic [C_DATA_WIDTH/8-1:0]                M_AXI_WSTRB,
    output logic                                     M_AXI_WVALID,
    input  logic                                     M_AXI_WREADY,
    input  logic [1:0]                               M_AXI_BRESP,
    input  logic                                     M_AXI_BVALID,
    output logic                                     M_AXI_BREADY,
    output logic [C_ADDR_WIDTH-1:0]                  M_AXI_ARADDR,
    output logic [2:0]                               M_AXI_ARPROT,
    output logic                                     M_AXI_ARVALID,
    input  logic                                     M_AXI_ARREADY,
    input  logic [C_DATA_WIDTH-1:0]                  M_AXI_RDATA,
    input  logic [1:0]                               M_AXI_RRESP,
    input  logic                                     M_AXI_RVALID,
    output logic                                     M_AXI_RREADY
);

    state_t                      state, next_state;
    logic                        last_grant, grant_q, grant_idx;
    logic [1:0]                  grant;
    logic [C_ADDR_WIDTH-1:0]     addr_q;
    logic [C_DATA_WIDTH-1:0]     wdata_q, rdata_q;
    logic [C_DATA_WIDTH/8-1:0]   wstrb_q;
    logic [1:0]                  resp_q;
    logic [N_REQ-1:0]            rsp_valid_q;
    logic                        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                        accept, aw_done, w_done;

    rr_arbiter_2 u_arb (
        .req_valid (req_valid),
        .last_grant(last_grant),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept    = (state == IDLE) && (req_valid != '0) && !ARESET;
    assign req_ready = accept ? grant : '0;

    // Each write channel is done once it has handshaken, now or earlier.
    assign aw_done = !awvalid_q || M_AXI_AWREADY;
    assign w_done  = !wvalid_q  || M_AXI_WREADY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (accept)               next_state = req_we[grant_idx] ? WR : RA;
            WR:   if (aw_done && w_done)    next_state = WB;
            WB:   if (M_AXI_BVALID)         next_state = RESP;
            RA:   if (M_AXI_ARREADY)        next_state = RD;
            RD:   if (M_AXI_RVALID)         next_state = RESP;
            RESP:                           next_state = IDLE;
            default:                        next_state = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            last_grant  <= 1'b1;
            grant_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
            rsp_valid_q <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    grant_q    <= grant_idx;
                    last_grant <= grant_idx;
                    addr_q     <= req_addr[grant_idx];
                    wdata_q    <= req_wdata[grant_idx];
                    wstrb_q    <= req_wstrb[grant_idx];
                    awvalid_q  <= req_we[grant_idx];
                    wvalid_q   <= req_we[grant_idx];
                    arvalid_q  <= !req_we[grant_idx];
                end
                WR: begin
                    if (M_AXI_AWREADY) awvalid_q <= 1'b0;
                    if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done) bready_q <= 1'b1;
                end
                WB: if (M_AXI_BVALID) begin
                    bready_q    <= 1'b0;
                    resp_q      <= M_AXI_BRESP;
                    rdata_q     <= '0;
                    rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
                end
                RA: if (M_AXI_ARREADY) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                end
                RD: if (M_AXI_RVALID) begin
                    rready_q    <= 1'b0;
                    rdata_q     <= M_AXI_RDATA;
                    resp_q      <= M_AXI_RRESP;
                    rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
                end
                RESP: rsp_valid_q <= '0;
                default: ;
            endcase
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
